// File: rtl/tic_tac_game.sv
// tic_tac_game -- two-player tic-tac-toe referee.
//
// Accepts moves for X and O in turn, rejects moves onto occupied or
// out-of-range cells, scores the board after every legal move and holds the
// result until a restart.
//
// Handshake: a move is consumed on a rising edge where move_valid_i=1 and
// move_ready_o=1. move_ready_o is registered and is high only while waiting
// for a move (PLAY_X / PLAY_O). A consumed move is either applied to the board
// or rejected with a one-cycle illegal_o pulse; it is never held or replayed.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   move_valid_i      a move is offered this cycle
//   move_pos_i[3:0]   target cell 0..8, row-major (bit n of board = cell n)
//   restart_i         clear the board and start a new game (beats a move)
//   move_ready_o      a move can be accepted this cycle
//   x_o[8:0], o_o[8:0] board occupancy for X and O
//   turn_o            0 = X to move, 1 = O to move
//   illegal_o         one-cycle pulse after a rejected move
//   winx_o, wino_o, draw_o, game_over_o   result flags
//   state_o[1:0]      current FSM state (debug observation)
//   move_cnt_o[3:0]   legal moves this game (only with TTT_MOVE_COUNT_EN)
//
// Configuration: define TTT_MOVE_COUNT_EN to add the move_cnt_o counter.
module tic_tac_game (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       move_valid_i,
    input  logic [3:0] move_pos_i,
    input  logic       restart_i,
    output logic       move_ready_o,
    output logic [8:0] x_o,
    output logic [8:0] o_o,
    output logic       turn_o,
    output logic       illegal_o,
    output logic       winx_o,
    output logic       wino_o,
    output logic       draw_o,
    output logic       game_over_o,
    output logic [1:0] state_o
`ifdef TTT_MOVE_COUNT_EN
    ,
    output logic [3:0] move_cnt_o
`endif
);

    typedef enum logic [1:0] {
        PLAY_X = 2'd0,
        PLAY_O = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [8:0] cell_mask;
    logic       pos_legal;
    logic [8:0] mover_board;

    // True when any of the 8 lines is fully occupied in board b.
    function automatic logic has_line(input logic [8:0] b);
        return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Out-of-range positions shift the mask to zero, so the range test must
    // be explicit rather than relying on the occupancy test.
    always_comb begin
        cell_mask   = 9'd1 << move_pos_i;
        pos_legal   = (move_pos_i <= 4'd8) && (((x_o | o_o) & cell_mask) == 9'd0);
        mover_board = turn_o ? o_o : x_o;
    end

    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= PLAY_X;
            move_ready_o <= 1'b0;
            x_o          <= 9'd0;
            o_o          <= 9'd0;
            turn_o       <= 1'b0;
            illegal_o    <= 1'b0;
            winx_o       <= 1'b0;
            wino_o       <= 1'b0;
            draw_o       <= 1'b0;
            game_over_o  <= 1'b0;
`ifdef TTT_MOVE_COUNT_EN
            move_cnt_o   <= 4'd0;
`endif
        end else if (restart_i) begin
            // Any move offered alongside restart is dropped silently.
            state        <= PLAY_X;
            move_ready_o <= 1'b1;
            x_o          <= 9'd0;
            o_o          <= 9'd0;
            turn_o       <= 1'b0;
            illegal_o    <= 1'b0;
            winx_o       <= 1'b0;
            wino_o       <= 1'b0;
            draw_o       <= 1'b0;
            game_over_o  <= 1'b0;
`ifdef TTT_MOVE_COUNT_EN
            move_cnt_o   <= 4'd0;
`endif
        end else begin
            illegal_o <= 1'b0;
            case (state)
                PLAY_X, PLAY_O: begin
                    // Also raises ready on the first edge after reset.
                    move_ready_o <= 1'b1;
                    if (move_valid_i && move_ready_o) begin
                        if (pos_legal) begin
                            if (state == PLAY_X) x_o <= x_o | cell_mask;
                            else                 o_o <= o_o | cell_mask;
                            state        <= CHECK;
                            move_ready_o <= 1'b0;
`ifdef TTT_MOVE_COUNT_EN
                            // At most 9 legal moves fit on the board, so
                            // the counter tops out at 9 on its own.
                            move_cnt_o   <= move_cnt_o + 4'd1;
`endif
                        end else begin
                            illegal_o <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Win is tested before full-board so a line on the ninth
                    // move scores as a win.
                    if (has_line(mover_board)) begin
                        state       <= DONE;
                        winx_o      <= ~turn_o;
                        wino_o      <= turn_o;
                        game_over_o <= 1'b1;
                    end else if ((x_o | o_o) == 9'h1FF) begin
                        state       <= DONE;
                        draw_o      <= 1'b1;
                        game_over_o <= 1'b1;
                    end else begin
                        state        <= turn_o ? PLAY_X : PLAY_O;
                        turn_o       <= ~turn_o;
                        move_ready_o <= 1'b1;
                    end
                end
                default: begin
                    // DONE holds board and result until restart.
                    move_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tic_tac_game.md
TIC_TAC_GAME -- requirements
Module: tic_tac_game

Interface
REQ-001 The module SHALL have ports clk_i (input, 1, the only clock, rising edge) and rst_i (input, 1, asynchronous active-high reset), listed first.
REQ-002 The module SHALL have move_valid_i (input, 1): a move is offered this cycle.
REQ-003 The module SHALL have move_pos_i (input, 4): the target cell, 0..8, row-major, with bit n of the board equal to cell n.
REQ-004 The module SHALL have restart_i (input, 1): clear the board and start a new game.
REQ-005 The module SHALL have move_ready_o (output, 1): the block accepts a move this cycle.
REQ-006 The module SHALL have x_o and o_o (output, 9 each): board occupancy vectors in the checker's x/o format.
REQ-007 The module SHALL have turn_o (output, 1): 0 = X to move, 1 = O to move.
REQ-008 The module SHALL have illegal_o (output, 1): a one-cycle pulse flagging a rejected move.
REQ-009 The module SHALL have winx_o, wino_o, draw_o and game_over_o (output, 1 each): game result flags.

Function
REQ-010 The FSM SHALL have four states: PLAY_X, PLAY_O, CHECK and DONE.
REQ-011 move_ready_o SHALL be 1 only in PLAY_X and PLAY_O.
REQ-012 A move SHALL be consumed when move_valid_i=1 and move_ready_o=1 on the same rising edge.
REQ-013 A consumed move SHALL be legal only if move_pos_i is at most 8 and the cell is clear in both x_o and o_o.
REQ-014 A legal move SHALL set its bit in x_o (from PLAY_X) or o_o (from PLAY_O) at the next edge, and the FSM SHALL enter CHECK; latency from handshake to board update is 1 cycle.
REQ-015 An illegal move SHALL leave the board unchanged, pulse illegal_o for exactly 1 cycle (the cycle after the handshake), and keep the FSM and turn unchanged.
REQ-016 CHECK SHALL last exactly 1 cycle and evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board for the mover only.
REQ-017 From CHECK, a mover line complete SHALL go to DONE with winx_o or wino_o set.
REQ-018 From CHECK, a full board with no line (x_o|o_o = 9'h1FF) SHALL go to DONE with draw_o set.
REQ-019 From CHECK, any other outcome SHALL go to the opposite PLAY state and toggle turn_o.
REQ-020 When a line completes on the ninth move, the result SHALL be a win, not a draw.
REQ-021 game_over_o SHALL equal 1 exactly when the FSM is in DONE; DONE SHALL hold the board and result until restart_i.
REQ-022 In any state, restart_i=1 at an edge SHALL clear x_o, o_o and all result flags, set turn_o=0, and go to PLAY_X.
REQ-023 restart_i SHALL take priority over a simultaneous move handshake, and that move SHALL be discarded with no illegal_o pulse.
REQ-024 x_o & o_o SHALL be 0 at all times, and at most one of winx_o, wino_o and draw_o SHALL be 1.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst_i=1 SHALL immediately, without a clock edge, force state PLAY_X, x_o=0, o_o=0, turn_o=0 and all flags 0.
REQ-027 While rst_i=1, move_ready_o SHALL be 0.
REQ-028 After rst_i deasserts, move_ready_o SHALL be 1 from the first clock edge onward.
REQ-029 Reset mid-game SHALL discard the in-flight move and any pending CHECK result.

Configuration
REQ-030 The macro TTT_MOVE_COUNT_EN SHALL control an accepted-move counter.
REQ-031 When TTT_MOVE_COUNT_EN is defined, the module SHALL add output move_cnt_o (4 bits) counting legal moves 0..9.
REQ-032 move_cnt_o SHALL increment together with the board update, clear on reset and restart, and never exceed 9.
REQ-033 When TTT_MOVE_COUNT_EN is undefined, move_cnt_o and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then moves 0,3,1,4,2 -> x_o=9'h007, o_o=9'h018, winx_o=1 one cycle after the fifth board update, game_over_o=1, move_ready_o=0.
REQ-035 X plays 0, then O plays 0 -> illegal_o pulses once, o_o=0, turn_o remains 1, and O's next move at 4 is accepted.
REQ-036 move_pos_i=4'd12 with valid -> illegal_o=1 for 1 cycle, board unchanged.
REQ-037 Sequence 0,1,2,4,3,5,7,6,8 -> draw_o=1 with x_o|o_o=9'h1FF and move_cnt_o=9 when the macro is defined.
REQ-038 restart_i asserted in the same cycle as a valid move in PLAY_O -> board 0, turn_o=0, no illegal_o pulse.
REQ-039 rst_i pulsed asynchronously mid-CHECK after a winning move -> winx_o stays 0, board 0, state PLAY_X.
